// File: rtl/spram_stream_reader_if.sv
`default_nettype none
// ============================================================================
//  Module      : spram_stream_reader_if
//  Description : Word-wide bus between a RAM master and the byte-write
//                single-port RAM. The RAM returns read data one cycle after
//                it samples the address (registered read).
//  Signals     : write       - write enable (master -> RAM)
//                address     - byte address (master -> RAM)
//                write_data  - write word (master -> RAM)
//                write_strb  - per-byte write enables (master -> RAM)
//                read_data   - word for the previous cycle's address (RAM -> master)
//  Revision    : 1.0 - initial release
// ============================================================================
interface spram_stream_reader_if #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32
);
    logic                    write;
    logic [ADDR_WIDTH-1:0]   address;
    logic [DATA_WIDTH-1:0]   write_data;
    logic [DATA_WIDTH/8-1:0] write_strb;
    logic [DATA_WIDTH-1:0]   read_data;

    modport master (
        output write,
        output address,
        output write_data,
        output write_strb,
        input  read_data
    );

    modport slave (
        input  write,
        input  address,
        input  write_data,
        input  write_strb,
        output read_data
    );
endinterface
`default_nettype wire

// File: rtl/spram_stream_reader.sv
`default_nettype none
// ============================================================================
//  Module      : spram_stream_reader
//  Description : Read-only master for the single-port RAM. A start command
//                launches a strided sequence of word reads; returning words
//                are buffered in a 2-entry FIFO and delivered as a
//                valid/ready stream with a last flag.
//  Ports       : clk, rst_n           - clock, async active-low reset
//                start                - command pulse (honoured only when idle)
//                base_addr            - byte address of word 0 (word aligned)
//                word_count           - words to read, 0 = no-op
//                stride               - word step between reads
//                busy, done           - command status / completion pulse
//                mem_if (master)      - RAM bus, write controls tied off
//                out_valid/ready/data/last - output word stream
//                stall_cycles         - optional back-pressure counter
//  Options     : define SPRAM_STREAM_READER_STALL_CNT_EN to add stall_cycles
//  Revision    : 1.0 - initial release
// ============================================================================
module spram_stream_reader #(
    parameter int ADDR_WIDTH = 32,
    parameter int DATA_WIDTH = 32,
    parameter int CNT_WIDTH  = 16
) (
    input  wire logic                  clk,
    input  wire logic                  rst_n,
    input  wire logic                  start,
    input  wire logic [ADDR_WIDTH-1:0] base_addr,
    input  wire logic [CNT_WIDTH-1:0]  word_count,
    input  wire logic [CNT_WIDTH-1:0]  stride,
    output logic                       busy,
    output logic                       done,
    spram_stream_reader_if.master      mem_if,
    output logic                       out_valid,
    input  wire logic                  out_ready,
    output logic [DATA_WIDTH-1:0]      out_data,
    output logic                       out_last
`ifdef SPRAM_STREAM_READER_STALL_CNT_EN
    ,
    output logic [31:0]                stall_cycles
`endif
);

    localparam int c_BYTES = DATA_WIDTH / 8;
    localparam int c_LSB   = $clog2(c_BYTES);
    localparam logic [ADDR_WIDTH-1:0] c_ALIGN_MASK = ~ADDR_WIDTH'(c_BYTES - 1);

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_RUN   = 2'd1,
        S_DRAIN = 2'd2
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic [ADDR_WIDTH-1:0] r_next_addr;   // address of the next read to issue
    logic [ADDR_WIDTH-1:0] r_last_addr;   // address of the most recent read
    logic [CNT_WIDTH-1:0]  r_stride;
    logic [CNT_WIDTH-1:0]  r_count;
    logic [CNT_WIDTH-1:0]  r_issued;

    // Set in the cycle the RAM presents data for a read issued one cycle earlier.
    logic                  r_in_flight;
    logic                  r_in_flight_last;

    logic [DATA_WIDTH-1:0] r_fifo_data [2];
    logic                  r_fifo_last [2];
    logic                  r_wptr;
    logic                  r_rptr;
    logic [1:0]            r_occ;
    logic                  r_done;

    logic                  w_pop;
    logic                  w_issue;
    logic                  w_issue_last;
    logic                  w_accept;
    logic                  w_done_nxt;
    logic [2:0]            w_committed;
    logic [ADDR_WIDTH-1:0] w_step;

    always_comb begin
        w_state_nxt  = r_state;
        w_pop        = (r_occ != 2'd0) && out_ready;
        // Slots already claimed once this cycle's pop is accounted for. Counting
        // the pop lets a read issue while the head word leaves, which is what
        // keeps the stream at one word per cycle with only two slots.
        w_committed  = {1'b0, r_occ} + {2'b00, r_in_flight} - {2'b00, w_pop};
        w_issue      = (r_state == S_RUN) && (r_issued < r_count) && (w_committed < 3'd2);
        w_issue_last = (r_issued == (r_count - CNT_WIDTH'(1)));
        w_accept     = (r_state == S_IDLE) && start;
        w_done_nxt   = 1'b0;
        w_step       = ADDR_WIDTH'(r_stride) << c_LSB;

        case (r_state)
            S_IDLE: begin
                if (start) begin
                    if (word_count != '0) begin
                        w_state_nxt = S_RUN;
                    end else begin
                        w_done_nxt = 1'b1;
                    end
                end
            end
            S_RUN: begin
                if (w_issue && w_issue_last) begin
                    w_state_nxt = S_DRAIN;
                end
            end
            S_DRAIN: begin
                if (w_pop && r_fifo_last[r_rptr]) begin
                    w_state_nxt = S_IDLE;
                    w_done_nxt  = 1'b1;
                end
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_next_addr      <= '0;
            r_last_addr      <= '0;
            r_stride         <= '0;
            r_count          <= '0;
            r_issued         <= '0;
            r_in_flight      <= 1'b0;
            r_in_flight_last <= 1'b0;
            r_wptr           <= 1'b0;
            r_rptr           <= 1'b0;
            r_occ            <= 2'd0;
            r_done           <= 1'b0;
            for (int i = 0; i < 2; i++) begin
                r_fifo_data[i] <= '0;
                r_fifo_last[i] <= 1'b0;
            end
        end else begin
            r_done <= w_done_nxt;

            if (w_accept && (word_count != '0)) begin
                r_next_addr <= base_addr & c_ALIGN_MASK;
                r_stride    <= stride;
                r_count     <= word_count;
                r_issued    <= '0;
            end

            if (w_issue) begin
                r_last_addr <= r_next_addr;
                r_next_addr <= r_next_addr + w_step;
                r_issued    <= r_issued + CNT_WIDTH'(1);
            end

            r_in_flight      <= w_issue;
            r_in_flight_last <= w_issue && w_issue_last;

            if (r_in_flight) begin
                r_fifo_data[r_wptr] <= mem_if.read_data;
                r_fifo_last[r_wptr] <= r_in_flight_last;
                r_wptr              <= ~r_wptr;
            end

            if (w_pop) begin
                r_rptr <= ~r_rptr;
            end

            case ({r_in_flight, w_pop})
                2'b10:   r_occ <= r_occ + 2'd1;
                2'b01:   r_occ <= r_occ - 2'd1;
                default: r_occ <= r_occ;
            endcase
        end
    end

`ifdef SPRAM_STREAM_READER_STALL_CNT_EN
    logic [31:0] r_stall_cycles;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_stall_cycles <= '0;
        end else if (w_accept) begin
            r_stall_cycles <= '0;
        end else if (busy && out_valid && !out_ready && (r_stall_cycles != '1)) begin
            r_stall_cycles <= r_stall_cycles + 32'd1;
        end
    end

    assign stall_cycles = r_stall_cycles;
`endif

    // The address is only meaningful in an issue cycle; otherwise it parks on
    // the last read address so the bus does not toggle needlessly.
    assign mem_if.address    = w_issue ? r_next_addr : r_last_addr;
    assign mem_if.write      = 1'b0;
    assign mem_if.write_data = '0;
    assign mem_if.write_strb = '0;

    assign busy      = (r_state != S_IDLE);
    assign done      = r_done;
    assign out_valid = (r_occ != 2'd0);
    assign out_data  = r_fifo_data[r_rptr];
    assign out_last  = out_valid && r_fifo_last[r_rptr];

endmodule
`default_nettype wire
